operand_fetch: RTL and testbench
================================

# operand_fetch

Issue-side initiator for the two-read/one-write register file. It accepts decoded instructions on a valid/ready handshake and drives the register file read addresses. It absorbs the file's one-cycle registered read latency and corrects stale read data when a same-cycle writeback hits. It presents operand-complete instructions to execute on a second valid/ready handshake. It also owns the register file write port, relaying writeback traffic so it can snoop every write.

## Interface
- PAYLOAD_W, 32, width of opaque instruction payload (opcode, imm, pc) carried alongside operands
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  block accepts instruction this cycle
- in_rs1, in_rs2, in_rd  in  5 each  source/destination register indices
- in_payload  in  PAYLOAD_W  opaque payload
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_rs1_val, out_rs2_val  out  32 each  resolved operand values
- out_rd  out  5  held destination index
- out_payload  out  PAYLOAD_W  held payload
- wb_en, wb_addr(5), wb_data(32)  in  writeback request
- rf_rs1, rf_rs2  out  5 each  to register file read addresses
- rf_rdata1, rf_rdata2  in  32 each  registered read data from file
- rf_wen, rf_waddr(5), rf_wdata(32)  out  to register file write port

## Operation
- Single-entry stage. Holds at most one instruction (held: rs1, rs2, rd, payload).
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept: capture fields; out_valid <= 1. On out_ready with no accept: out_valid <= 0.
- Read address mux (combinational): rf_rsN = accept ? in_rsN : held rsN.
  - The file re-reads the held registers every stalled cycle, so rf_rdataN always reflects file state as of the previous edge.
- Write relay: rf_wen/rf_waddr/rf_wdata = wb_en/wb_addr/wb_data, combinational with no delay.
- Same-edge hazard: the file returns the pre-write value when read and write share an edge. Per operand N, at every edge:
  - bypN_v <= wb_en && wb_addr == rf_rsN && rf_rsN != 0
  - bypN_d <= wb_data
- Output: out_rsN_val = (held rsN == 0) ? 0 : bypN_v ? bypN_d : rf_rdataN.
- x0: reads always yield 0. Writebacks to x0 are relayed (the file discards them) and never set bypN_v.
- rs1 == rs2 is legal. Both bypass paths fire independently on the same write.
- A write to the held rd has no effect on this block.

## Timing
- Reset: out_valid=0, held rs1/rs2/rd=0, out_payload=0, byp1_v=byp2_v=0. in_ready=1 from reset.
- Latency: instruction accepted at edge N is presented with out_valid=1 in the cycle after edge N.
- Full throughput: with out_ready held high, one instruction per cycle back-to-back.
- During a stall (out_valid && !out_ready), outputs are stable except out_rsN_val. A writeback to a held source at edge K updates out_rsN_val in the cycle after K.
- Writeback in the same cycle as accept, targeting in_rs1: out_rs1_val equals the new wb_data on first presentation.
- Writeback one cycle after accept, targeting the held rs: visible via the file read one cycle later (file updated before re-read). out_rsN_val carries the old value for one cycle, then the new value.
- Simultaneous accept and drain: old instruction leaves, new one presented next cycle. out_valid stays 1.
- Reset mid-operation: held instruction is dropped and out_valid falls asynchronously. Register file contents are untouched (the file has no reset).

## Test plan
- Preload x5=0x11, x6=0x22 via writeback. Accept rs1=5, rs2=6, rd=7, payload 0xABC -> next cycle out_valid=1, values 0x11/0x22, out_rd=7, out_payload=0xABC.
- Accept rs1=5 while wb_en writes x5=0xDEAD in the same cycle -> out_rs1_val=0xDEAD on first presentation.
- Stall with out_ready=0, write x6=0x99 -> out_rs2_val becomes 0x99 the next cycle. in_ready stays 0 and payload is stable.
- rs1=rs2=0 with a concurrent writeback to x0 of 0xFFFF -> both operands 0, byp never valid.
- Stream 8 instructions with out_ready=1 -> 8 consecutive out_valid cycles, in order, with correct operands.
- Assert resetn low while out_valid=1 -> out_valid=0 immediately. After release, in_ready=1 and a previously written x5 reads back unchanged.

Source files
------------

// File: rtl/operand_fetch.sv
// Single-entry operand fetch stage: drives register file reads, relays writebacks, and bypasses same-edge writes.
// Operands appear one cycle after accept; in_ready = !out_valid || out_ready, so one instruction per cycle when execute keeps up.
module operand_fetch #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_rs1_val,
  output logic [31:0]          out_rs2_val,
  output logic [4:0]           out_rd,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [31:0]          wb_data,
  output logic [4:0]           rf_rs1,
  output logic [4:0]           rf_rs2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata
);

  logic                 r_out_valid;
  logic [4:0]           r_rs1;
  logic [4:0]           r_rs2;
  logic [4:0]           r_rd;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_byp1_v;
  logic                 r_byp2_v;
  logic [31:0]          r_byp1_d;
  logic [31:0]          r_byp2_d;

  logic                 w_accept;
  logic                 w_byp1_hit;
  logic                 w_byp2_hit;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Read the incoming sources on accept, otherwise keep re-reading the held ones
  assign rf_rs1 = w_accept ? in_rs1 : r_rs1;
  assign rf_rs2 = w_accept ? in_rs2 : r_rs2;

  assign rf_wen   = wb_en;
  assign rf_waddr = wb_addr;
  assign rf_wdata = wb_data;

  // The file returns pre-write data when read and write share an edge
  assign w_byp1_hit = wb_en && (wb_addr == rf_rs1) && (rf_rs1 != 5'd0);
  assign w_byp2_hit = wb_en && (wb_addr == rf_rs2) && (rf_rs2 != 5'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_payload   <= '0;
      r_byp1_v    <= 1'b0;
      r_byp2_v    <= 1'b0;
      r_byp1_d    <= 32'd0;
      r_byp2_d    <= 32'd0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_rs1       <= in_rs1;
        r_rs2       <= in_rs2;
        r_rd        <= in_rd;
        r_payload   <= in_payload;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_byp1_v <= w_byp1_hit;
      r_byp2_v <= w_byp2_hit;
      r_byp1_d <= wb_data;
      r_byp2_d <= wb_data;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_rd      = r_rd;
  assign out_payload = r_payload;
  assign out_rs1_val = (r_rs1 == 5'd0) ? 32'd0 : (r_byp1_v ? r_byp1_d : rf_rdata1);
  assign out_rs2_val = (r_rs2 == 5'd0) ? 32'd0 : (r_byp2_v ? r_byp2_d : rf_rdata2);

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 2R1W register file (registered reads, pre-write data on shared edge).
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_payload;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic [31:0] out_payload;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch #(.PAYLOAD_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_payload(out_payload),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // Register file: no reset, registered reads, x0 hardwired to zero
  always @(posedge clk) begin
    rf_rdata1 <= (rf_rs1 == 5'd0) ? 32'd0 : mem[rf_rs1];
    rf_rdata2 <= (rf_rs2 == 5'd0) ? 32'd0 : mem[rf_rs2];
    if (rf_wen && rf_waddr != 5'd0) mem[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic [31:0] p);
    in_valid = v; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_payload = p;
  endtask

  task automatic drive_wb(input logic e, input logic [4:0] a, input logic [31:0] dat);
    wb_en = e; wb_addr = a; wb_data = dat;
  endtask

  initial begin
    resetn = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_payload", out_payload, 32'd0);
    check("rst_rd", {27'd0, out_rd}, 32'd0);
    check("rst_rs1_val", out_rs1_val, 32'd0);
    resetn = 1'b1;
    tick();

    // Preload x5, x6 and check the write relay
    drive_wb(1'b1, 5'd5, 32'h11);
    #1;
    check("relay_wen", {31'd0, rf_wen}, 32'd1);
    check("relay_waddr", {27'd0, rf_waddr}, 32'd5);
    check("relay_wdata", rf_wdata, 32'h11);
    tick();
    drive_wb(1'b1, 5'd6, 32'h22);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);

    // Basic accept
    out_ready = 1'b1;
    drive_in(1'b1, 5'd5, 5'd6, 5'd7, 32'hABC);
    #1;
    check("accept_rf_rs1", {27'd0, rf_rs1}, 32'd5);
    check("accept_rf_rs2", {27'd0, rf_rs2}, 32'd6);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    check("basic_rs1", out_rs1_val, 32'h11);
    check("basic_rs2", out_rs2_val, 32'h22);
    check("basic_rd", {27'd0, out_rd}, 32'd7);
    check("basic_payload", out_payload, 32'hABC);
    check("held_rf_rs1", {27'd0, rf_rs1}, 32'd5);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Writeback coincident with accept
    drive_in(1'b1, 5'd5, 5'd6, 5'd8, 32'h123);
    drive_wb(1'b1, 5'd5, 32'hDEAD);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    out_ready = 1'b0;
    #1;
    check("sameedge_rs1", out_rs1_val, 32'hDEAD);
    check("sameedge_rs2", out_rs2_val, 32'h22);
    tick();
    check("sameedge_rs1_file", out_rs1_val, 32'hDEAD);

    // Stall with writeback to a held source
    drive_wb(1'b1, 5'd6, 32'h99);
    #1;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_rs2_old", out_rs2_val, 32'h22);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    #1;
    check("stall_rs2_byp", out_rs2_val, 32'h99);
    check("stall_payload", out_payload, 32'h123);
    check("stall_rd", {27'd0, out_rd}, 32'd8);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("stall_rs2_file", out_rs2_val, 32'h99);
    check("stall_rs1_keep", out_rs1_val, 32'hDEAD);
    out_ready = 1'b1;
    tick();

    // x0 sources with a writeback to x0
    drive_in(1'b1, 5'd0, 5'd0, 5'd1, 32'h55);
    drive_wb(1'b1, 5'd0, 32'hFFFF);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    #1;
    check("x0_rs1", out_rs1_val, 32'd0);
    check("x0_rs2", out_rs2_val, 32'd0);
    check("x0_byp1_v", {31'd0, dut.r_byp1_v}, 32'd0);
    check("x0_byp2_v", {31'd0, dut.r_byp2_v}, 32'd0);
    tick();

    // rs1 == rs2 with a coincident write: both paths bypass
    drive_in(1'b1, 5'd5, 5'd5, 5'd2, 32'h66);
    drive_wb(1'b1, 5'd5, 32'h77);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    #1;
    check("dup_rs1", out_rs1_val, 32'h77);
    check("dup_rs2", out_rs2_val, 32'h77);
    tick();

    // Preload x1..x8 = 0x100+k, then stream 8 back-to-back
    for (int k = 1; k <= 8; k++) begin
      drive_wb(1'b1, k[4:0], 32'h100 + k);
      tick();
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_in(1'b1, 5'd1, 5'd8, 5'd0, 32'd1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_rs1", out_rs1_val, 32'h100 + i);
      check("stream_rs2", out_rs2_val, 32'h109 - i);
      check("stream_payload", out_payload, (i - 1) * 3 + 1);
      if (i < 8) drive_in(1'b1, 5'(i + 1), 5'(8 - i), 5'(i), i * 3 + 1);
      else       drive_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
      tick();
    end
    check("stream_end_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while holding an instruction
    out_ready = 1'b0;
    drive_in(1'b1, 5'd6, 5'd7, 5'd3, 32'h77);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    check("prerst_valid", {31'd0, out_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_payload", out_payload, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    drive_in(1'b1, 5'd5, 5'd0, 5'd4, 32'h88);
    tick();
    drive_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    check("postrst_rs1", out_rs1_val, 32'h105);
    check("postrst_rs2", out_rs2_val, 32'd0);
    check("postrst_payload", out_payload, 32'h88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
